// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the 5-stage MIPS pipeline hazard controller:
// opcode/funct encodings, forwarding-select encodings, the in-flight tracker
// entry type and the forwarding priority helper.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_WIDTH  = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int LINK_REG_IDX = 31;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes that change register usage (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  is_load;
    } trk_entry_t;

    localparam trk_entry_t TRK_EMPTY = '0;

    // Operand source for one EX register read. EX/MEM wins over MEM/WB because
    // it holds the younger result. A load in MEM has no data yet, so it never
    // forwards from EX/MEM; the stall guarantees it is consumed from MEM/WB.
    function automatic logic [1:0] fwd_select(
        input logic                  mem_valid,
        input logic [REG_ADDR_W-1:0] mem_dest,
        input logic                  mem_is_load,
        input logic                  wb_valid,
        input logic [REG_ADDR_W-1:0] wb_dest,
        input logic [REG_ADDR_W-1:0] src
    );
        logic [1:0] sel;
        if (mem_valid && (mem_dest != '0) && (mem_dest == src) && !mem_is_load) begin
            sel = FWD_EXMEM;
        end else if (wb_valid && (wb_dest != '0) && (wb_dest == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mips_reg_use_decode.sv
// -----------------------------------------------------------------------------
// mips_reg_use_decode
// Combinational register-usage decode of one instruction.
//   instr    in   instruction word
//   rs, rt   out  raw source register fields
//   uses_rs  out  instruction reads rs
//   uses_rt  out  instruction reads rt
//   dest     out  destination register, 0 when nothing is written
//   is_load  out  instruction is lw
//   is_jump  out  instruction is j / jal / jr
// Unknown opcodes decode as a NOP (no uses, no dest).
// -----------------------------------------------------------------------------
module mips_reg_use_decode
    import mips_pkg::*;
#(
    parameter int INSTR_W  = INSTR_WIDTH,
    parameter int REG_AW   = REG_ADDR_W,
    parameter int LINK_REG = LINK_REG_IDX
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rt,
    output logic               uses_rs,
    output logic               uses_rt,
    output logic [REG_AW-1:0]  dest,
    output logic               is_load,
    output logic               is_jump
);

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rd_s;
    logic              unused_shamt_s;

    assign opcode_s       = instr[31:26];
    assign funct_s        = instr[5:0];
    assign rs             = instr[25:21];
    assign rt             = instr[20:16];
    assign rd_s           = instr[15:11];
    assign unused_shamt_s = ^instr[10:6];

    // Classify the instruction into operand usage, destination and kind
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        dest    = '0;
        is_load = 1'b0;
        is_jump = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        uses_rt = 1'b1;
                        dest    = rd_s;
                    end
                    FN_JR: begin
                        uses_rs = 1'b1;
                        is_jump = 1'b1;
                    end
                    default: begin
                        uses_rs = 1'b1;
                        uses_rt = 1'b1;
                        dest    = rd_s;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: begin
                uses_rs = 1'b1;
                dest    = rt;
            end
            OP_LW: begin
                uses_rs = 1'b1;
                dest    = rt;
                is_load = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                dest    = REG_AW'(LINK_REG);
                is_jump = 1'b1;
            end
            default: begin
                uses_rs = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// mips_hazard_ctrl
// Pipeline sequencing controller for a 5-stage MIPS CPU. Tracks the
// destinations of instructions in EX/MEM/WB, stalls on load-use, flushes on a
// taken branch or a jump, and selects EX operand forwarding.
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   run enable; 0 freezes tracker and counter
//   id_valid     in   IF/ID holds a real instruction
//   id_instr     in   instruction in ID
//   ex_br_taken  in   beq/bne in EX resolved taken
//   pc_write_en  out  PC may advance
//   ifid_wr_en   out  IF/ID may load
//   ifid_flush   out  IF/ID loads an all-zero NOP
//   idex_bubble  out  ID/EX loads a NOP
//   fwd_a/fwd_b  out  EX rs/rt source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt    out  saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int INSTR_W  = INSTR_WIDTH,
    parameter int REG_AW   = REG_ADDR_W,
    parameter int LINK_REG = LINK_REG_IDX
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               ex_br_taken,
    output logic               pc_write_en,
    output logic               ifid_wr_en,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [15:0]        stall_cnt
);

    logic [REG_AW-1:0] dec_rs_s;
    logic [REG_AW-1:0] dec_rt_s;
    logic              dec_uses_rs_s;
    logic              dec_uses_rt_s;
    logic [REG_AW-1:0] dec_dest_s;
    logic              dec_is_load_s;
    logic              dec_is_jump_s;

    trk_entry_t trk_ex_r;
    trk_entry_t trk_mem_r;
    trk_entry_t trk_wb_r;
    trk_entry_t ex_next_s;

    logic [15:0] stall_cnt_r;
    logic        load_use_s;
    logic        stall_count_s;
    logic        bubble_s;
    logic        unused_trk_s;

    mips_reg_use_decode #(
        .INSTR_W  (INSTR_W),
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .instr    (id_instr),
        .rs       (dec_rs_s),
        .rt       (dec_rt_s),
        .uses_rs  (dec_uses_rs_s),
        .uses_rt  (dec_uses_rt_s),
        .dest     (dec_dest_s),
        .is_load  (dec_is_load_s),
        .is_jump  (dec_is_jump_s)
    );

    // Fields the hazard logic never looks at once an entry leaves EX
    assign unused_trk_s = ^{trk_mem_r.rs, trk_mem_r.rt, trk_wb_r.rs, trk_wb_r.rt, trk_wb_r.is_load};

    // Load in EX whose result the ID instruction needs next cycle
    always_comb begin
        if (trk_ex_r.valid && trk_ex_r.is_load && (trk_ex_r.dest != '0)) begin
            load_use_s = (dec_uses_rs_s && (dec_rs_s == trk_ex_r.dest)) ||
                         (dec_uses_rt_s && (dec_rt_s == trk_ex_r.dest));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A taken branch squashes the stalled instruction, so that cycle is not a stall
    assign stall_count_s = start && !ex_br_taken && load_use_s;

    // Pipeline control priority: reset, freeze, taken branch, load-use, jump
    always_comb begin
        pc_write_en = 1'b1;
        ifid_wr_en  = 1'b1;
        ifid_flush  = 1'b0;
        bubble_s    = 1'b0;
        if (reset) begin
            pc_write_en = 1'b1;
        end else if (!start) begin
            pc_write_en = 1'b0;
            ifid_wr_en  = 1'b0;
        end else if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            bubble_s    = 1'b1;
        end else if (load_use_s) begin
            pc_write_en = 1'b0;
            ifid_wr_en  = 1'b0;
            bubble_s    = 1'b1;
        end else if (id_valid && dec_is_jump_s) begin
            ifid_flush  = 1'b1;
        end else begin
            pc_write_en = 1'b1;
        end
    end

    assign idex_bubble = bubble_s;

    // Entry that enters EX on the next advance
    always_comb begin
        if (bubble_s || !id_valid) begin
            ex_next_s = TRK_EMPTY;
        end else begin
            ex_next_s.valid   = 1'b1;
            ex_next_s.dest    = dec_dest_s;
            ex_next_s.rs      = dec_rs_s;
            ex_next_s.rt      = dec_rt_s;
            ex_next_s.is_load = dec_is_load_s;
        end
    end

    // In-flight tracker shift register EX -> MEM -> WB
    always_ff @(posedge clock) begin
        if (reset) begin
            trk_ex_r  <= TRK_EMPTY;
            trk_mem_r <= TRK_EMPTY;
            trk_wb_r  <= TRK_EMPTY;
        end else if (start) begin
            trk_ex_r  <= ex_next_s;
            trk_mem_r <= trk_ex_r;
            trk_wb_r  <= trk_mem_r;
        end else begin
            trk_ex_r  <= trk_ex_r;
            trk_mem_r <= trk_mem_r;
            trk_wb_r  <= trk_wb_r;
        end
    end

    // Saturating load-use stall counter
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_count_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

    // Forwarding selects from the registered tracker, held while frozen
    always_comb begin
        if (reset) begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end else begin
            fwd_a = fwd_select(trk_mem_r.valid, trk_mem_r.dest, trk_mem_r.is_load,
                               trk_wb_r.valid, trk_wb_r.dest, trk_ex_r.rs);
            fwd_b = fwd_select(trk_mem_r.valid, trk_mem_r.dest, trk_mem_r.is_load,
                               trk_wb_r.valid, trk_wb_r.dest, trk_ex_r.rt);
        end
    end

endmodule
